seq_unary_reduce: RTL and testbench

SEQ_UNARY_REDUCE -- requirements
Module: seq_unary_reduce

---
 rtl/seq_unary_reduce_pkg.sv | 22 ++
 rtl/unary_chunk_reduce.sv | 22 ++
 rtl/seq_unary_reduce.sv | 105 ++++++++++
 tb/tb_seq_unary_reduce.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seq_unary_reduce_pkg.sv
// Shared types and helpers for the sequential unary reduction block.
package seq_unary_reduce_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_base_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // The reserved code behaves as AND, so it shares AND's identity value.
    function automatic logic identity_value(input op_base_e op_base);
        return (op_base == OP_AND) || (op_base == OP_RSVD);
    endfunction

endpackage

// File: rtl/unary_chunk_reduce.sv
// Combinational fold of one W-bit chunk into the running reduction bit.
module unary_chunk_reduce
    import seq_unary_reduce_pkg::*;
#(
    parameter int W = 2
) (
    input  logic [W-1:0] chunk,
    input  logic         acc,
    input  op_base_e     op_base,
    output logic         acc_next
);

    always_comb begin
        acc_next = acc & (&chunk);
        case (op_base)
            OP_OR:   acc_next = acc | (|chunk);
            OP_XOR:  acc_next = acc ^ (^chunk);
            default: acc_next = acc & (&chunk);
        endcase
    end

endmodule

// File: rtl/seq_unary_reduce.sv
// Multi-cycle AND/OR/XOR reduction of an N-bit operand, W bits per cycle,
// with valid/ready handshakes on both the operand and result sides.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | folding one chunk per edge, LSB chunk first
// DONE  | result presented, held until out_ready
module seq_unary_reduce
    import seq_unary_reduce_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         c,
    output logic         busy
);

    localparam int CHUNKS = (W >= 1) ? N / W : 1;
    localparam int CW     = $clog2(CHUNKS + 1);

    generate
        if (W < 1 || (N % W) != 0) begin : g_bad_params
            $error("seq_unary_reduce: N must be a positive multiple of W");
        end
    endgenerate

    state_e        state;
    state_e        state_next;
    logic          acc;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_reg;
    logic [2:0]    op_reg;

    logic          accept;
    logic          last_chunk;
    logic [W-1:0]  chunk;
    logic          acc_next;
    op_base_e      base_reg;

    assign base_reg   = op_base_e'(op_reg[1:0]);
    assign accept     = in_valid && (state == IDLE);
    assign last_chunk = (cnt == CW'(CHUNKS - 1));
    assign chunk      = a_reg[int'(cnt) * W +: W];

    unary_chunk_reduce #(.W(W)) u_chunk (
        .chunk    (chunk),
        .acc      (acc),
        .op_base  (base_reg),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        c          = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                c         = acc ^ op_reg[2];
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= 1'b0;
            cnt    <= '0;
            a_reg  <= '0;
            op_reg <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg  <= a;
                op_reg <= op;
                acc    <= identity_value(op_base_e'(op[1:0]));
                cnt    <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_unary_reduce.sv
// Self-checking bench for seq_unary_reduce (N=8, W=2): directed operands
// with literal expectations plus a per-cycle comparison against a behavioural model.
module tb_seq_unary_reduce;

    localparam int N   = 8;
    localparam int W   = 2;
    localparam int LAT = N / W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         c;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    seq_unary_reduce #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic ref_reduce(input logic [N-1:0] v, input logic [2:0] o);
        logic r;
        r = (o[1:0] == 2'b01 || o[1:0] == 2'b10) ? 1'b0 : 1'b1;
        for (int i = 0; i < N; i++) begin
            case (o[1:0])
                2'b01:   r = r | v[i];
                2'b10:   r = r ^ v[i];
                default: r = r & v[i];
            endcase
        end
        return r ^ o[2];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation is pending for LAT edges, then its
    // result is offered until out_ready is seen on an edge.
    logic m_active = 1'b0;
    int   m_edges  = 0;
    logic m_c      = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_edges  = 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1'b1;
                m_edges  = 0;
                m_c      = ref_reduce(a, op);
            end
        end else if (m_edges < LAT) begin
            m_edges++;
        end else if (out_ready) begin
            m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready",  in_ready,  !m_active);
            check("busy",      busy,      m_active);
            check("out_valid", out_valid, m_active && m_edges == LAT);
            check("c",         c,         (m_active && m_edges == LAT) ? m_c : 1'b0);
        end
    end

    task automatic run_op(input logic [N-1:0] av, input logic [2:0] opv,
                          input logic exp_c, input int hold, input string name);
        int   lat;
        logic c_held;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = av;
        op        = opv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = N'($urandom);
        op       = 3'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, LAT);
        end
        check({name, " result"}, c, exp_c);
        check({name, " model"}, ref_reduce(av, opv), exp_c);
        c_held = c;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            a        = N'($urandom);
            @(posedge clk); #1;
            check({name, " hold valid"}, out_valid, 1'b1);
            check({name, " hold c"}, c, c_held);
            check({name, " hold in_ready"}, in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (hold > 0) begin
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        check({name, " back idle"}, in_ready, 1'b1);
        check({name, " valid drop"}, out_valid, 1'b0);
    endtask

    initial begin
        #2;
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset c", c, 1'b0);
        check("reset busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'hFF, 3'b000, 1'b1, 0, "and_ff");
        run_op(8'hFE, 3'b000, 1'b0, 0, "and_fe");
        run_op(8'h00, 3'b001, 1'b0, 0, "or_00");
        run_op(8'h00, 3'b101, 1'b1, 0, "nor_00");
        run_op(8'h07, 3'b010, 1'b1, 0, "xor_07");
        run_op(8'h07, 3'b110, 1'b0, 0, "xnor_07");
        run_op(8'hFF, 3'b011, 1'b1, 0, "rsvd_ff");
        run_op(8'h7F, 3'b011, 1'b0, 0, "rsvd_7f");
        run_op(8'h80, 3'b001, 1'b1, 0, "or_80");
        run_op(8'h81, 3'b010, 1'b0, 0, "xor_81");
        run_op(8'hFF, 3'b100, 1'b0, 0, "nand_ff");
        run_op(8'h5A, 3'b010, 1'b0, 5, "xor_hold");
        run_op(8'h01, 3'b001, 1'b1, 5, "or_hold");

        // Abort mid-run with an asynchronous reset.
        in_valid = 1'b1;
        a        = 8'h00;
        op       = 3'b101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort in_ready", in_ready, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort out_valid", out_valid, 1'b0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort no pulse", out_valid, 1'b0);
        end
        run_op(8'hFF, 3'b000, 1'b1, 0, "after_abort");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
